// File: rtl/ascii_pkg.sv
// Shared constants, state type and weight lookup for the binary-to-ASCII encoder.
package ascii_pkg;

   localparam logic [19:0] DEC_WEIGHT [0:5] = '{20'd1, 20'd10, 20'd100, 20'd1000, 20'd10000,
                                               20'd100000};
   localparam logic [7:0]  ASCII_ZERO = 8'h30;
   localparam logic [19:0] MAX_VALUE  = 20'd999999;

   typedef enum logic [1:0] {IDLE, CONV, SEND} state_e;

   // Out-of-range places map to weight 0; the FSM never produces them.
   function automatic logic [19:0] place_weight(input logic [2:0] place);
      logic [19:0] w;
      case (place)
         3'd0:    w = DEC_WEIGHT[0];
         3'd1:    w = DEC_WEIGHT[1];
         3'd2:    w = DEC_WEIGHT[2];
         3'd3:    w = DEC_WEIGHT[3];
         3'd4:    w = DEC_WEIGHT[4];
         3'd5:    w = DEC_WEIGHT[5];
         default: w = 20'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/ascii_digit_extract.sv
// Combinational single-digit extractor: finds the decimal digit at one place of the
// remainder with a parallel compare ladder and returns the reduced remainder.
module ascii_digit_extract
   import ascii_pkg::*;
(
   input  logic [19:0] remainder,
   input  logic [2:0]  place,
   output logic [3:0]  digit,
   output logic [19:0] next_rem
);

   logic [19:0] w_weight;
   logic [8:0]  w_ge;
   logic [19:0] w_sub;

   assign w_weight = place_weight(place);

   // Ladder: w_ge[k-1] set when k*W fits in the remainder (thermometer code).
   always_comb begin
      w_ge = '0;
      for (int k = 1; k <= 9; k++) begin
         w_ge[k-1] = ((20'(k) * w_weight) <= remainder);
      end
   end

   // Highest set rung of the thermometer is the digit.
   always_comb begin
      digit = 4'd0;
      for (int k = 1; k <= 9; k++) begin
         if (w_ge[k-1]) digit = 4'(k);
      end
   end

   // Products fit in 20 bits (9*100000), so truncation is lossless.
   assign w_sub    = 20'(digit) * w_weight;
   assign next_rem = remainder - w_sub;

endmodule

// File: rtl/bin_to_ascii_encoder.sv
// Converts a 20-bit binary value into a decimal ASCII string, MSD first, one character
// per valid/ready handshake, with optional leading-zero suppression.
module bin_to_ascii_encoder
   import ascii_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 6,
   parameter bit          SUPPRESS_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [19:0] bin_in,
   output logic        start_ready,
   output logic [7:0]  ascii_out,
   output logic        ascii_valid,
   input  logic        ascii_ready,
   output logic        ascii_last,
   output logic        error
);

   localparam logic [2:0] PLACE_TOP = 3'(NUM_DIGITS - 1);

   state_e      r_state, w_state_nxt;
   logic [19:0] r_rem, w_rem_nxt;
   logic [2:0]  r_place, w_place_nxt;
   logic        r_nz_seen, w_nz_seen_nxt;
   logic [7:0]  r_ascii, w_ascii_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_last, w_last_nxt;
   logic        r_error, w_error_nxt;

   logic [3:0]  w_digit;
   logic [19:0] w_next_rem;
   logic        w_skip;

   ascii_digit_extract u_extract (
      .remainder (r_rem),
      .place     (r_place),
      .digit     (w_digit),
      .next_rem  (w_next_rem)
   );

   // Leading zero is dropped unless it is the units place (value 0 still prints '0').
   assign w_skip = SUPPRESS_LZ && (w_digit == 4'd0) && !r_nz_seen && (r_place != 3'd0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and datapath next values; everything holds unless a branch updates it.
   always_comb begin
      w_state_nxt   = r_state;
      w_rem_nxt     = r_rem;
      w_place_nxt   = r_place;
      w_nz_seen_nxt = r_nz_seen;
      w_ascii_nxt   = r_ascii;
      w_valid_nxt   = r_valid;
      w_last_nxt    = r_last;
      w_error_nxt   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               if (bin_in > MAX_VALUE) begin
                  w_error_nxt = 1'b1;
               end else begin
                  w_rem_nxt     = bin_in;
                  w_place_nxt   = PLACE_TOP;
                  w_nz_seen_nxt = 1'b0;
                  w_state_nxt   = CONV;
               end
            end
         end
         CONV: begin
            w_rem_nxt = w_next_rem;
            if (w_skip) begin
               w_place_nxt = r_place - 3'd1;
            end else begin
               w_ascii_nxt   = ASCII_ZERO + {4'd0, w_digit};
               w_valid_nxt   = 1'b1;
               w_last_nxt    = (r_place == 3'd0);
               w_nz_seen_nxt = 1'b1;
               w_state_nxt   = SEND;
            end
         end
         SEND: begin
            if (ascii_ready) begin
               w_valid_nxt = 1'b0;
               if (r_place == 3'd0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_place_nxt = r_place - 3'd1;
                  w_state_nxt = CONV;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem     <= 20'd0;
         r_place   <= PLACE_TOP;
         r_nz_seen <= 1'b0;
         r_ascii   <= 8'h00;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_rem     <= w_rem_nxt;
         r_place   <= w_place_nxt;
         r_nz_seen <= w_nz_seen_nxt;
         r_ascii   <= w_ascii_nxt;
         r_valid   <= w_valid_nxt;
         r_last    <= w_last_nxt;
         r_error   <= w_error_nxt;
      end
   end

   assign start_ready = (r_state == IDLE);
   assign ascii_out   = r_ascii;
   assign ascii_valid = r_valid;
   assign ascii_last  = r_last;
   assign error       = r_error;

endmodule

// File: tb/tb_bin_to_ascii_encoder.sv
// Directed bench for bin_to_ascii_encoder: scoreboard of expected characters per DUT,
// one instance with leading-zero suppression and one without.
module tb_bin_to_ascii_encoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start_a = 1'b0, ready_a = 1'b1;
   logic [19:0] bin_a = '0;
   logic        sr_a, valid_a, last_a, err_a;
   logic [7:0]  ascii_a;

   logic        start_b = 1'b0, ready_b = 1'b1;
   logic [19:0] bin_b = '0;
   logic        sr_b, valid_b, last_b, err_b;
   logic [7:0]  ascii_b;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] q_a[$];
   logic [8:0] q_b[$];

   always #5 clk = ~clk;

   bin_to_ascii_encoder #(.NUM_DIGITS(6), .SUPPRESS_LZ(1'b1)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_a),
      .bin_in      (bin_a),
      .start_ready (sr_a),
      .ascii_out   (ascii_a),
      .ascii_valid (valid_a),
      .ascii_ready (ready_a),
      .ascii_last  (last_a),
      .error       (err_a)
   );

   bin_to_ascii_encoder #(.NUM_DIGITS(6), .SUPPRESS_LZ(1'b0)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_b),
      .bin_in      (bin_b),
      .start_ready (sr_b),
      .ascii_out   (ascii_b),
      .ascii_valid (valid_b),
      .ascii_ready (ready_b),
      .ascii_last  (last_b),
      .error       (err_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard pop on every accepted character.
   always @(negedge clk) begin
      if (rst_n && valid_a && ready_a) begin
         n_cmp++;
         assert (q_a.size() != 0) else begin
            n_err++;
            $error("FAIL a_extra_char: observed %0h expected none", {last_a, ascii_a});
         end
         if (q_a.size() != 0) check("a_char", 32'({last_a, ascii_a}), 32'(q_a.pop_front()));
      end
      if (rst_n && valid_b && ready_b) begin
         n_cmp++;
         assert (q_b.size() != 0) else begin
            n_err++;
            $error("FAIL b_extra_char: observed %0h expected none", {last_b, ascii_b});
         end
         if (q_b.size() != 0) check("b_char", 32'({last_b, ascii_b}), 32'(q_b.pop_front()));
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: decimal digits by division, MSD first, optional LZ suppression.
   task automatic expect_value(input int which, input int unsigned v, input bit slz);
      int unsigned p;
      int unsigned d;
      bit          seen;
      logic [8:0]  e;
      p    = 100000;
      seen = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         d = (v / p) % 10;
         if (d != 0) seen = 1'b1;
         if (seen || !slz || i == 0) begin
            e = {(i == 0), 8'h30 + 8'(d)};
            if (which == 0) q_a.push_back(e);
            else            q_b.push_back(e);
         end
         p = p / 10;
      end
   endtask

   task automatic send_a(input logic [19:0] v);
      start_a = 1'b1;
      bin_a   = v;
      tick();
      start_a = 1'b0;
   endtask

   task automatic send_b(input logic [19:0] v);
      start_b = 1'b1;
      bin_b   = v;
      tick();
      start_b = 1'b0;
   endtask

   task automatic wait_done(input int which, input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (which == 0) done = (q_a.size() == 0) && sr_a && !valid_a;
         else            done = (q_b.size() == 0) && sr_b && !valid_b;
         if (done) break;
         tick();
      end
      check(tag, 32'(done), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sr"},    32'(sr_a),    32'd1);
      check({tag, "_ascii"}, 32'(ascii_a), 32'h00);
      check({tag, "_valid"}, 32'(valid_a), 32'd0);
      check({tag, "_last"},  32'(last_a),  32'd0);
      check({tag, "_err"},   32'(err_a),   32'd0);
      check({tag, "_b_valid"}, 32'(valid_b), 32'd0);
      check({tag, "_b_err"},   32'(err_b),   32'd0);
   endtask

   initial begin
      int  cnt;
      bit  ok;

      // Reset values
      #2;
      check_reset_outputs("rst");
      tick();
      rst_n = 1'b1;
      tick();

      // 123456 with latency check: CONV one cycle, then '1' visible
      expect_value(0, 123456, 1'b1);
      send_a(20'd123456);
      check("lat_conv_valid", 32'(valid_a), 32'd0);
      check("lat_conv_sr", 32'(sr_a), 32'd0);
      tick();
      check("lat_first_valid", 32'(valid_a), 32'd1);
      check("lat_first_char", 32'(ascii_a), 32'h31);
      wait_done(0, "done_123456");

      // 42 with suppression: four skip cycles before '4'
      expect_value(0, 42, 1'b1);
      send_a(20'd42);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (valid_a) break;
         tick();
         cnt++;
      end
      check("lz_skip_cycles", 32'(cnt), 32'd5);
      wait_done(0, "done_42_lz");

      // 42 without suppression
      expect_value(1, 42, 1'b0);
      send_b(20'd42);
      wait_done(1, "done_42_nolz");

      // Zero and inner zeros
      expect_value(0, 0, 1'b1);
      send_a(20'd0);
      wait_done(0, "done_0");
      expect_value(0, 100000, 1'b1);
      send_a(20'd100000);
      wait_done(0, "done_100000");

      // Out of range: single-cycle error, no characters
      send_a(20'd1000000);
      check("err_pulse", 32'(err_a), 32'd1);
      check("err_sr", 32'(sr_a), 32'd1);
      check("err_valid", 32'(valid_a), 32'd0);
      tick();
      check("err_clear", 32'(err_a), 32'd0);
      check("err_valid2", 32'(valid_a), 32'd0);
      check("err_sr2", 32'(sr_a), 32'd1);

      // 999999 with three stall cycles per character; start during busy is ignored
      expect_value(0, 999999, 1'b1);
      ready_a = 1'b0;
      send_a(20'd999999);
      for (int c = 0; c < 6; c++) begin
         ok = 1'b0;
         for (int i = 0; i < 10; i++) begin
            if (valid_a) begin
               ok = 1'b1;
               break;
            end
            tick();
         end
         check("stall_valid_seen", 32'(ok), 32'd1);
         for (int s = 0; s < 3; s++) begin
            if (c == 0) begin
               start_a = 1'b1;
               bin_a   = 20'd5;
            end
            check("stall_hold_valid", 32'(valid_a), 32'd1);
            check("stall_hold_char", 32'(ascii_a), 32'h39);
            check("stall_hold_last", 32'(last_a), 32'(c == 5));
            tick();
         end
         if (c == 0) begin
            check("busy_sr", 32'(sr_a), 32'd0);
            start_a = 1'b0;
         end
         ready_a = 1'b1;
         tick();
         ready_a = 1'b0;
      end
      ready_a = 1'b1;
      wait_done(0, "done_999999");

      // Reset while the third character is held
      q_a.push_back({1'b0, 8'h31});
      q_a.push_back({1'b0, 8'h32});
      send_a(20'd123456);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (valid_a && ascii_a == 8'h33) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("rst_mid_reached", 32'(ok), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      check("rst_mid_queue", 32'(q_a.size()), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      expect_value(0, 7, 1'b1);
      send_a(20'd7);
      wait_done(0, "done_7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
